// File: rtl/cp0_exception_controller_pkg.sv
// Shared CP0 constants: exception codes, register numbers, SR/Cause field positions.
package cp0_exception_controller_pkg;

    localparam logic [4:0] ExcCode_Int  = 5'd0;
    localparam logic [4:0] ExcCode_AdEL = 5'd4;
    localparam logic [4:0] ExcCode_AdES = 5'd5;
    localparam logic [4:0] ExcCode_RI   = 5'd10;
    localparam logic [4:0] ExcCode_Ov   = 5'd12;
    localparam logic [4:0] No_ExcCode   = 5'd31;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EX_LO = 2;
    localparam int CAUSE_EX_HI = 6;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_BD    = 31;

endpackage

// File: rtl/cp0_exception_controller_if.sv
// Pipeline-to-CP0 bundle: M-stage exception info, mtc0/mfc0 access, flush request.
interface cp0_exception_controller_if;

    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;
    logic [31:0] HandlerPC;

    modport master (
        output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req, HandlerPC
    );

    modport slave (
        input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req, HandlerPC
    );

endinterface

// File: rtl/cp0_exception_controller_req_arbiter.sv
// Combinational exception/interrupt request and recorded-code selection.
module cp0_req_arbiter
    import cp0_exception_controller_pkg::*;
(
    input  logic       exl,
    input  logic       ie,
    input  logic [5:0] im,
    input  logic [5:0] hwint,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] exc_code_sel
);

    // Interrupt has priority over a pipelined exception; nothing is taken inside the handler.
    always_comb begin
        int_req      = !exl && ie && |(hwint & im);
        exc_req      = !exl && (exc_code_in != No_ExcCode);
        req          = int_req || exc_req;
        exc_code_sel = int_req ? ExcCode_Int : exc_code_in;
    end

endmodule

// File: rtl/cp0_exception_controller.sv
// CP0 register file (SR/Cause/EPC/PRID) and exception entry/return sequencing.
module cp0_exception_controller
    import cp0_exception_controller_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h0000_2024,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic                           clk,
    input  logic                           reset_n,
    cp0_exception_controller_if.slave      bus
);

    logic [5:0]  sr_im;
    logic        sr_exl;   // NORMAL (0) / HANDLER (1) state
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req, exc_req, arb_req;
    logic [4:0]  exc_code_sel;
    logic [31:0] sr_word, cause_word;

    cp0_req_arbiter u_arb (
        .exl          (sr_exl),
        .ie           (sr_ie),
        .im           (sr_im),
        .hwint        (bus.HWInt),
        .exc_code_in  (bus.ExcCodeIn),
        .int_req      (int_req),
        .exc_req      (exc_req),
        .req          (arb_req),
        .exc_code_sel (exc_code_sel)
    );

    // Request is suppressed while reset is held so a reset cycle never flushes.
    always_comb begin
        bus.Req       = arb_req && reset_n;
        bus.HandlerPC = HANDLER_PC;
        bus.EPCOut    = epc;
    end

    // Register views and mfc0 read mux (pre-edge state, no write bypass).
    always_comb begin
        sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
        cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
        case (bus.CP0Add)
            CP0_SR:    bus.CP0Out = sr_word;
            CP0_CAUSE: bus.CP0Out = cause_word;
            CP0_EPC:   bus.CP0Out = epc;
            CP0_PRID:  bus.CP0Out = PRID;
            default:   bus.CP0Out = 32'b0;
        endcase
    end

    // Exception entry beats mtc0; eret clears EXL after any same-cycle SR write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= bus.HWInt;
            if (arb_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= exc_code_sel;
                cause_bd  <= bus.BDIn;
                epc       <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
            end else begin
                if (bus.en && bus.CP0Add == CP0_SR) begin
                    sr_im  <= bus.CP0In[SR_IM_HI:SR_IM_LO];
                    sr_exl <= bus.CP0In[SR_EXL];
                    sr_ie  <= bus.CP0In[SR_IE];
                end
                if (bus.en && bus.CP0Add == CP0_EPC)
                    epc <= bus.CP0In;
                if (bus.EXLClr)
                    sr_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception_controller.sv
// Scoreboard bench: expectations queued when stimulus is applied, checked mid-cycle.
module tb_cp0_exception_controller;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cp0_exception_controller_if bus();

    cp0_exception_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        int          sel;   // 0 Req, 1 CP0Out, 2 EPCOut, 3 HandlerPC
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference state
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {31'b0, bus.Req};
            1:       return bus.CP0Out;
            2:       return bus.EPCOut;
            default: return bus.HandlerPC;
        endcase
    endfunction

    task automatic idle();
        bus.en = 0; bus.CP0Add = 0; bus.CP0In = 0; bus.VPC = 0; bus.BDIn = 0;
        bus.ExcCodeIn = 5'd31; bus.HWInt = 0; bus.EXLClr = 0;
    endtask

    // One clock: queue model outputs, compare at negedge, advance model at posedge.
    task automatic cyc(input string tag);
        logic        mi, me, mr;
        logic [31:0] mrd;
        exp_t        e;
        mi = !m_exl && m_ie && |(bus.HWInt & m_im);
        me = !m_exl && (bus.ExcCodeIn != 5'd31);
        mr = (mi || me) && reset_n;
        case (bus.CP0Add)
            5'd12:   mrd = {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   mrd = {m_bd, 15'b0, m_ip, 3'b0, m_code, 2'b0};
            5'd14:   mrd = m_epc;
            5'd15:   mrd = 32'h0000_2024;
            default: mrd = 32'b0;
        endcase
        push({tag, ".req"}, 0, {31'b0, mr});
        if (reset_n) begin
            push({tag, ".rd"}, 1, mrd);
            push({tag, ".epc"}, 2, m_epc);
        end
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
        if (!reset_n) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0;
        end else begin
            m_ip = bus.HWInt;
            if (mr) begin
                m_exl  = 1;
                m_code = mi ? 5'd0 : bus.ExcCodeIn;
                m_bd   = bus.BDIn;
                m_epc  = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
            end else begin
                if (bus.en && bus.CP0Add == 5'd12) begin
                    m_im = bus.CP0In[15:10]; m_exl = bus.CP0In[1]; m_ie = bus.CP0In[0];
                end
                if (bus.en && bus.CP0Add == 5'd14) m_epc = bus.CP0In;
                if (bus.EXLClr) m_exl = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0;
        idle();
        reset_n = 0;
        @(posedge clk);
        #1;

        // 1: reset, then mfc0 of every CP0 register
        cyc("rst0");
        cyc("rst1");
        reset_n = 1;
        bus.CP0Add = 12; push("t1.sr", 1, 32'h0);          cyc("t1a");
        bus.CP0Add = 13; push("t1.cause", 1, 32'h0);       cyc("t1b");
        bus.CP0Add = 14; push("t1.epc", 1, 32'h0);         cyc("t1c");
        bus.CP0Add = 15; push("t1.prid", 1, 32'h0000_2024);
        push("t1.hpc", 3, 32'h0000_4180);                  cyc("t1d");

        // 2: overflow in a delay slot
        bus.ExcCodeIn = 12; bus.VPC = 32'h3008; bus.BDIn = 1; bus.CP0Add = 13;
        push("t2.req", 0, 32'h1);                          cyc("t2a");
        idle(); bus.CP0Add = 13; push("t2.cause", 1, 32'h8000_0030); cyc("t2b");
        bus.CP0Add = 14; push("t2.epc", 1, 32'h0000_3004); cyc("t2c");
        bus.CP0Add = 12; push("t2.sr", 1, 32'h0000_0002);  cyc("t2d");

        // 3: interrupt beats a simultaneous exception
        bus.EXLClr = 1;                                    cyc("t3clr");
        idle(); bus.en = 1; bus.CP0Add = 12; bus.CP0In = 32'h0000_0401; cyc("t3sr");
        idle(); bus.HWInt = 6'b000001; bus.ExcCodeIn = 4; bus.VPC = 32'h5000;
        push("t3.req", 0, 32'h1);                          cyc("t3a");
        idle(); bus.HWInt = 6'b000001; bus.CP0Add = 13;
        push("t3.cause", 1, 32'h0000_0400);                cyc("t3b");

        // 4: nesting blocked while EXL=1, pending interrupt taken after eret
        bus.ExcCodeIn = 5; bus.VPC = 32'h6000;
        push("t4.noreq", 0, 32'h0);                        cyc("t4a");
        bus.ExcCodeIn = 31; bus.CP0Add = 14;
        push("t4.epc", 1, 32'h0000_5000);                  cyc("t4b");
        bus.EXLClr = 1; push("t4.clrreq", 0, 32'h0);       cyc("t4c");
        bus.EXLClr = 0; bus.VPC = 32'h7000;
        push("t4.pend", 0, 32'h1);                         cyc("t4d");
        bus.HWInt = 0; bus.EXLClr = 1;
        push("t4.epc2", 2, 32'h0000_7000);                 cyc("t4e");

        // 5: masked SR write, read-only Cause, mtc0 lost to Req, eret vs SR write
        idle(); bus.en = 1; bus.CP0Add = 12; bus.CP0In = 32'hFFFF_FFFF; cyc("t5a");
        idle(); bus.CP0Add = 12; push("t5.sr", 1, 32'h0000_FC03); cyc("t5b");
        bus.en = 1; bus.CP0Add = 13; bus.CP0In = 32'hFFFF_FFFF;   cyc("t5c");
        idle(); bus.CP0Add = 13; push("t5.cause", 1, 32'h0);      cyc("t5d");
        bus.EXLClr = 1;                                           cyc("t5e");
        idle(); bus.en = 1; bus.CP0Add = 14; bus.CP0In = 32'h1234_5678;
        bus.ExcCodeIn = 10; bus.VPC = 32'h8000;
        push("t5.req", 0, 32'h1);                                 cyc("t5f");
        idle(); bus.CP0Add = 14; push("t5.epc", 1, 32'h0000_8000); cyc("t5g");
        bus.en = 1; bus.CP0Add = 12; bus.CP0In = 32'h0000_0002; bus.EXLClr = 1; cyc("t5h");
        idle(); bus.CP0Add = 12; push("t5.exlclr", 1, 32'h0);     cyc("t5i");

        // 6: EPC wrap, then reset in the handler
        bus.VPC = 32'h0; bus.BDIn = 1; bus.ExcCodeIn = 12;
        push("t6.req", 0, 32'h1);                                 cyc("t6a");
        idle(); bus.CP0Add = 14; push("t6.wrap", 1, 32'hFFFF_FFFC); cyc("t6b");
        bus.ExcCodeIn = 4; reset_n = 0;
        push("t6.rstreq", 0, 32'h0);                              cyc("t6c");
        reset_n = 1; bus.ExcCodeIn = 31; bus.CP0Add = 12;
        push("t6.sr", 1, 32'h0); push("t6.epcout", 2, 32'h0);     cyc("t6d");
        bus.CP0Add = 13; push("t6.cause", 1, 32'h0);              cyc("t6e");
        bus.CP0Add = 14; push("t6.epc", 1, 32'h0);                cyc("t6f");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
